// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer: buffers execute-stage memory requests and feeds memory_access_unit one op per cycle.
//  Read data is returned on a tagged valid/ready response port.
//  Ports:
//    clk, rst_n                   clock (rising edge), asynchronous active-low reset
//    req_valid/req_ready          request handshake; req_op 00 rd, 01 wr, 10 add, 11 sub
//    req_addr/req_data/req_tag    request word address, operand, tag
//    rsp_valid/rsp_ready          response handshake; rsp_data/rsp_tag held while stalled
//    mau_addr/mau_data_in/mau_mem_op  registered MAU command bus (00 when idle)
//    mau_data_out                 MAU read data, sampled in RD_WAIT
//    busy                         FIFO non-empty, op in flight or response pending
//    fifo_count                   request FIFO occupancy
//  Build option: define MEM_SEQ_WRITE_ACK_EN to make every write-type op return a zero-data response.
module mem_request_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [31:0]              mau_addr,
  output logic [31:0]              mau_data_in,
  output logic [1:0]               mau_mem_op,
  input  logic [31:0]              mau_data_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t state, state_nx;
  logic [1:0]       f_op   [DEPTH];
  logic [31:0]      f_addr [DEPTH];
  logic [31:0]      f_data [DEPTH];
  logic [TAG_W-1:0] f_tag  [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [TAG_W-1:0] cur_tag;
  logic             push, issue, wr_cur, ack, slot_free, rsp_load;
  assign req_ready = fifo_count != FULL;
  assign push      = req_valid && req_ready;
  assign busy      = (fifo_count != '0) || (state != IDLE) || rsp_valid;
  // mau_mem_op is the registered copy of the op in ISSUE, so it tells reads from write-types there.
  always_comb begin
    wr_cur    = (state == ISSUE) && (mau_mem_op != 2'b00);
    slot_free = !rsp_valid || rsp_ready;
`ifdef MEM_SEQ_WRITE_ACK_EN
    // A write-type op in ISSUE loads its ack this cycle, so nothing may pop behind it until the slot drains.
    ack   = wr_cur;
    issue = (fifo_count != '0) && (state == IDLE) && slot_free;
`else
    ack   = 1'b0;
    issue = (fifo_count != '0) && ((state == IDLE) || wr_cur) && slot_free;
`endif
    rsp_load = (state == RD_WAIT) || ack;
    state_nx = state;
    if (state == RD_WAIT)
      state_nx = IDLE;
    else if (state == ISSUE && !wr_cur)
      state_nx = RD_WAIT;
    else
      state_nx = issue ? ISSUE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wp]   <= req_op;
      f_addr[wp] <= req_addr;
      f_data[wp] <= req_data;
      f_tag[wp]  <= req_tag;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      fifo_count  <= '0;
      mau_addr    <= '0;
      mau_data_in <= '0;
      mau_mem_op  <= 2'b00;
      cur_tag     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
    end else begin
      state      <= state_nx;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(issue);
      mau_mem_op <= issue ? f_op[rp] : 2'b00;
      if (push) wp <= wp + AW'(1);
      if (issue) begin
        rp          <= rp + AW'(1);
        mau_addr    <= f_addr[rp];
        mau_data_in <= f_data[rp];
        cur_tag     <= f_tag[rp];
      end
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_data  <= (state == RD_WAIT) ? mau_data_out : '0;
        rsp_tag   <= cur_tag;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb_mem_request_sequencer: directed and random checks of mem_request_sequencer against a request-order memory model.
module tb_mem_request_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef MEM_SEQ_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  typedef struct {logic [31:0] data; logic [TAG_W-1:0] tag;} rsp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, busy;
  logic [1:0] req_op = '0, mau_mem_op;
  logic [31:0] req_addr = '0, req_data = '0, rsp_data, mau_addr, mau_data_in, mau_data_out = '0;
  logic [TAG_W-1:0] req_tag = '0, rsp_tag;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [31:0] mau_mem [0:255];
  logic [31:0] ref_mem [0:255];
  rsp_t exp_q [$];
  int n_assert = 0, n_fail = 0, n_rsp = 0;
  bit acc = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [TAG_W-1:0] prev_tag;
  mem_request_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .mau_addr(mau_addr), .mau_data_in(mau_data_in), .mau_mem_op(mau_mem_op),
    .mau_data_out(mau_data_out), .busy(busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  // Registered memory stand-in: data_out follows the address of the previous cycle, updates land at the edge.
  always @(posedge clk) begin
    mau_data_out <= mau_mem[mau_addr[7:0]];
    case (mau_mem_op)
      2'b01: mau_mem[mau_addr[7:0]] <= mau_data_in;
      2'b10: mau_mem[mau_addr[7:0]] <= mau_mem[mau_addr[7:0]] + mau_data_in;
      2'b11: mau_mem[mau_addr[7:0]] <= mau_mem[mau_addr[7:0]] - mau_data_in;
      default: ;
    endcase
  end
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  // One clock: sample mid-cycle, score handshakes, apply accepted requests to the model in order.
  task automatic cyc();
    rsp_t e;
    logic [7:0] a;
    @(negedge clk);
    if (prev_stall) begin
      chk("rsp_hold_valid", 32'(rsp_valid), 1);
      chk("rsp_hold_data", rsp_data, prev_data);
      chk("rsp_hold_tag", 32'(rsp_tag), 32'(prev_tag));
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_data = rsp_data;
    prev_tag = rsp_tag;
    acc = req_valid && req_ready;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
    if (acc) begin
      a = req_addr[7:0];
      case (req_op)
        2'b00: exp_q.push_back('{ref_mem[a], req_tag});
        2'b01: ref_mem[a] = req_data;
        2'b10: ref_mem[a] = ref_mem[a] + req_data;
        default: ref_mem[a] = ref_mem[a] - req_data;
      endcase
      if (ACK && req_op != 2'b00) exp_q.push_back('{32'h0, req_tag});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [TAG_W-1:0] tag);
    req_op = op;
    req_addr = addr;
    req_data = data;
    req_tag = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (acc) break;
    end
    chk("push_accepted", 32'(acc), 1);
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input logic [TAG_W-1:0] tag, output int lat);
    lat = 0;
    while (!(rsp_valid && rsp_tag == tag) && lat < 40) begin
      cyc();
      lat++;
    end
  endtask
  task automatic drain(input string name);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && busy; i++) cyc();
    chk({name, "_idle"}, 32'(busy), 0);
    chk({name, "_fifo_empty"}, 32'(fifo_count), 0);
    chk({name, "_all_rsp_seen"}, 32'(exp_q.size()), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n0;
    for (int i = 0; i < 256; i++) begin
      mau_mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_tag", 32'(rsp_tag), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_mau_addr", mau_addr, 0);
    chk("reset_mau_data_in", mau_data_in, 0);
    chk("reset_mau_op", 32'(mau_mem_op), 0);
    rst_n = 1'b1;
    chk("reset_req_ready", 32'(req_ready), 1);
    // 1: write then read of the same word; read response appears on the third edge after its acceptance edge
    push(2'b01, 32'd10, 32'hABCD, 4'd1);
    push(2'b00, 32'd10, 32'h0, 4'd2);
    chk("t1_mau_op", 32'(mau_mem_op), 1);
    chk("t1_mau_addr", mau_addr, 32'd10);
    chk("t1_mau_data", mau_data_in, 32'hABCD);
    wait_rsp(4'd2, lat);
    chk("t1_rsp_seen", 32'(rsp_valid && rsp_tag == 4'd2), 1);
    chk("t1_rsp_data", rsp_data, 32'hABCD);
    chk("t1_latency", 32'(lat), ACK ? 32'd4 : 32'd3);
    drain("t1");
    // 2: write/add/read, then sub/read
    push(2'b01, 32'd10, 32'h1234, 4'd1);
    push(2'b10, 32'd10, 32'h1234, 4'd2);
    push(2'b00, 32'd10, 32'h0, 4'd3);
    wait_rsp(4'd3, lat);
    chk("t2_add_data", rsp_data, 32'h2468);
    push(2'b11, 32'd10, 32'h1234, 4'd4);
    push(2'b00, 32'd10, 32'h0, 4'd5);
    wait_rsp(4'd5, lat);
    chk("t2_sub_data", rsp_data, 32'h1234);
    drain("t2");
    // 3: response stall holds the first read and keeps the second queued
    push(2'b01, 32'd3, 32'h33, 4'd14);
    push(2'b01, 32'd4, 32'h44, 4'd15);
    drain("t3_setup");
    rsp_ready = 1'b0;
    push(2'b00, 32'd3, 32'h0, 4'd6);
    push(2'b00, 32'd4, 32'h0, 4'd7);
    repeat (8) cyc();
    chk("t3_held_valid", 32'(rsp_valid), 1);
    chk("t3_held_tag", 32'(rsp_tag), 6);
    chk("t3_held_data", rsp_data, 32'h33);
    chk("t3_second_queued", 32'(fifo_count), 1);
    rsp_ready = 1'b1;
    wait_rsp(4'd7, lat);
    chk("t3_second_data", rsp_data, 32'h44);
    drain("t3");
    // 4: fill the FIFO behind a stalled response
    rsp_ready = 1'b0;
    push(2'b00, 32'd3, 32'h0, 4'd8);
    repeat (6) cyc();
    for (int k = 0; k < DEPTH; k++) push(2'b00, 32'(k), 32'h0, TAG_W'(9 + k));
    chk("t4_full_count", 32'(fifo_count), DEPTH);
    req_op = 2'b00;
    req_addr = 32'd4;
    req_tag = 4'd13;
    req_valid = 1'b1;
    repeat (3) cyc();
    chk("t4_not_accepted", 32'(acc), 0);
    chk("t4_req_ready_low", 32'(req_ready), 0);
    chk("t4_count_capped", 32'(fifo_count), DEPTH);
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) cyc();
    chk("t4_late_accept", 32'(acc), 1);
    req_valid = 1'b0;
    drain("t4");
    // 5: reset while the second read of a burst waits for data with the FIFO full
    for (int k = 0; k < 6; k++) push(2'b00, 32'(k), 32'h0, TAG_W'(k));
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_tag", 32'(rsp_tag), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_fifo_count", 32'(fifo_count), 0);
    chk("t5_mau_op", 32'(mau_mem_op), 0);
    chk("t5_mau_addr", mau_addr, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_rsp;
    repeat (12) cyc();
    chk("t5_no_rsp_after_reset", 32'(n_rsp - n0), 0);
    chk("t5_req_ready", 32'(req_ready), 1);
    // 6: write-type responses exist only with the acknowledge build option
    n0 = n_rsp;
    push(2'b01, 32'd20, 32'h55, 4'd5);
    repeat (6) cyc();
    chk("t6_ack_count", 32'(n_rsp - n0), ACK ? 32'd1 : 32'd0);
    drain("t6");
    // random traffic against the request-order model
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op = 2'($urandom_range(0, 3));
      req_addr = 32'($urandom_range(0, 15));
      req_data = $urandom;
      req_tag = TAG_W'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      cyc();
      chk("rand_count_bound", 32'(fifo_count <= DEPTH), 1);
    end
    drain("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
